// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and
// the helper that sizes the bit counter from the operand width.
package serial_adder_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder; the only arithmetic logic in the serial adder.
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: feeds one operand bit pair per clock, LSB
// first, through a single full-adder cell with the carry held in a flop.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] ra_q, rb_q, sum_q;
    logic [WIDTH-2:0] sh_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q, cout_q, ovf_q, done_q;

    logic             cell_s, cell_co;
    logic [WIDTH-1:0] sh_d;

    fa_cell u_fa_cell (
        .a    (ra_q[0]),
        .b    (rb_q[0]),
        .cin  (c_q),
        .sum  (cell_s),
        .cout (cell_co)
    );

    // Sum bits enter at the MSB end, so after WIDTH shifts bit 0 sits at sum[0].
    assign sh_d = {cell_s, sh_q};

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the shift registers are reset too, so sum reads 0 straight out of reset.
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            sh_q    <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout, so every term below reads pre-edge values.
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        ra_q    <= a;
                        rb_q    <= b;
                        c_q     <= cin;
                        cnt_q   <= '0;
                        sh_q    <= '0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    ra_q  <= ra_q >> 1;
                    rb_q  <= rb_q >> 1;
                    sh_q  <= sh_d[WIDTH-1:1];
                    c_q   <= cell_co;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        sum_q   <= sh_d;
                        cout_q  <= cell_co;
                        ovf_q   <= c_q ^ cell_co;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = (state_q == SHIFT);
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder and its fa_cell, with hand-computed results.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a, b;
    logic         cin;
    logic         busy, done, cout, ovf;
    logic [W-1:0] sum;

    logic fa_a, fa_b, fa_cin, fa_sum, fa_cout;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    fa_cell u_fa (
        .a    (fa_a),
        .b    (fa_b),
        .cin  (fa_cin),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Pulses start for one cycle; returns at the negedge after the accepting edge.
    task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
        @(negedge clk);
        a = av; b = bv; cin = cv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Waits (bounded) for done; reports cycles taken and any protocol slips seen.
    task automatic wait_done(input int limit, output int cycles, output bit proto_ok, output bit sum_moved);
        logic [W-1:0] s0;
        s0 = sum; cycles = 0; proto_ok = 1'b1; sum_moved = 1'b0;
        while (done !== 1'b1 && cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (done === 1'b1 && busy !== 1'b0) proto_ok = 1'b0;
            if (done !== 1'b1 && busy !== 1'b1) proto_ok = 1'b0;
            if (done !== 1'b1 && sum !== s0) sum_moved = 1'b1;
        end
    endtask

    task automatic check_result(input string name, input int exp_cycles, input logic [W-1:0] es,
                                input logic ec, input logic eo);
        int cycles; bit proto_ok, sum_moved;
        wait_done(20, cycles, proto_ok, sum_moved);
        total++; if (cycles !== exp_cycles) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, cycles, exp_cycles); end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL %s done: got %b want 1", name, done); end
        total++; if (proto_ok !== 1'b1) begin bad++; $display("FAIL %s busy/done protocol: got %b want 1", name, proto_ok); end
        total++; if (sum_moved !== 1'b0) begin bad++; $display("FAIL %s sum moved mid-run: got %b want 0", name, sum_moved); end
        total++; if (sum !== es) begin bad++; $display("FAIL %s sum: got %h want %h", name, sum, es); end
        total++; if (cout !== ec) begin bad++; $display("FAIL %s cout: got %b want %b", name, cout, ec); end
        total++; if (ovf !== eo) begin bad++; $display("FAIL %s ovf: got %b want %b", name, ovf, eo); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
        total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset sum: got %h want 00", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset cout: got %b want 0", cout); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset ovf: got %b want 0", ovf); end
    endtask

    task automatic test_fa_cell();
        logic [1:0] exp_tab [8];
        logic [2:0] in_v;
        exp_tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        for (int i = 0; i < 8; i++) begin
            in_v = 3'(i);
            {fa_a, fa_b, fa_cin} = in_v;
            #1;
            total++;
            if ({fa_cout, fa_sum} !== exp_tab[i]) begin
                bad++;
                $display("FAIL fa_cell in=%b: got %b want %b", in_v, {fa_cout, fa_sum}, exp_tab[i]);
            end
        end
    endtask

    task automatic test_add_basic();
        start_op(8'h35, 8'h4A, 1'b0);
        check_result("add_35_4a", 8, 8'h7F, 1'b0, 1'b0);
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done pulse width: got %b want 0", done); end
        total++; if (sum !== 8'h7F) begin bad++; $display("FAIL sum hold: got %h want 7f", sum); end
    endtask

    task automatic test_carry_out();
        start_op(8'hFF, 8'h01, 1'b0);
        check_result("add_ff_01", 8, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_overflow();
        start_op(8'h7F, 8'h00, 1'b1);
        a = 8'hAA; b = 8'h55; cin = 1'b0;  // late operand changes must not leak in
        check_result("add_7f_00_c1", 8, 8'h80, 1'b0, 1'b1);
    endtask

    task automatic test_ignore_start();
        start_op(8'h10, 8'h20, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_result("ignore_start", 5, 8'h30, 1'b0, 1'b0);
    endtask

    // Entered in the done cycle of the previous run.
    task automatic test_back_to_back();
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b accept busy: got %b want 1", busy); end
        check_result("b2b", 8, 8'h02, 1'b0, 1'b0);
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        start_op(8'h11, 8'h22, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort done: got %b want 0", done); end
        total++; if (sum !== 8'h00) begin bad++; $display("FAIL abort sum: got %h want 00", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL abort cout: got %b want 0", cout); end
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL abort ovf: got %b want 0", ovf); end
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
        end
        total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL abort stray activity: got %b want 0", saw_done); end
        start_op(8'h80, 8'h80, 1'b1);
        check_result("post_reset_80_80_c1", 8, 8'h01, 1'b1, 1'b1);
    endtask

    initial begin
        test_reset();
        test_fa_cell();
        test_add_basic();
        test_carry_out();
        test_overflow();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
